// File: rtl/decode_stage.sv
// MiniMIPS decode stage: register file with write-through bypass, control decode,
// and early branch/jump resolution. All outputs are combinational.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       InstrD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic              RegWriteW,
    input  logic [4:0]        WriteRegW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              ForwardAD,
    input  logic              ForwardBD,
    input  logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] RD1D,
    output logic [DATA_W-1:0] RD2D,
    output logic [4:0]        RsD,
    output logic [4:0]        RtD,
    output logic [4:0]        RdD,
    output logic [DATA_W-1:0] SignImmD,
    output logic              RegWriteD,
    output logic              MemtoRegD,
    output logic              MemWriteD,
    output logic              ALUSrcD,
    output logic              RegDstD,
    output logic              BranchD,
    output logic              JumpD,
    output logic [2:0]        ALUControlD,
    output logic              PCSrcD,
    output logic [DATA_W-1:0] PCBranchD,
    output logic [DATA_W-1:0] PCJumpD
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [DATA_W-1:0] rf [0:REG_N-1];
    logic              wr_en;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;

    assign opcode = InstrD[31:26];
    assign funct  = InstrD[5:0];
    assign RsD    = InstrD[25:21];
    assign RtD    = InstrD[20:16];
    assign RdD    = InstrD[15:11];
    assign wr_en  = RegWriteW && (WriteRegW != 5'd0);

    // NOTE: the array is reset as a whole because RST must clear architectural state;
    // this costs flops instead of RAM, which is acceptable for a 32-entry file.
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < REG_N; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[WriteRegW] <= ResultW;
        end
    end

    // Bypass the WB write into the read ports so the value is usable in the same cycle.
    always_comb begin
        if (RsD == 5'd0)                      RD1D = '0;
        else if (wr_en && WriteRegW == RsD)   RD1D = ResultW;
        else                                  RD1D = rf[RsD];

        if (RtD == 5'd0)                      RD2D = '0;
        else if (wr_en && WriteRegW == RtD)   RD2D = ResultW;
        else                                  RD2D = rf[RtD];
    end

    assign SignImmD = {{(DATA_W-16){InstrD[15]}}, InstrD[15:0]};

    // NOTE: every output gets a default first so no path leaves a value held (no latch).
    always_comb begin
        RegWriteD   = 1'b0;
        MemtoRegD   = 1'b0;
        MemWriteD   = 1'b0;
        ALUSrcD     = 1'b0;
        RegDstD     = 1'b0;
        BranchD     = 1'b0;
        JumpD       = 1'b0;
        ALUControlD = 3'b000;
        unique case (opcode)
            OP_RTYPE: begin
                // Unsupported funct (including the all-zero bubble) stays a full NOP.
                if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                    funct == FN_OR  || funct == FN_SLT) begin
                    RegWriteD = 1'b1;
                    RegDstD   = 1'b1;
                    case (funct)
                        FN_ADD:  ALUControlD = 3'b010;
                        FN_SUB:  ALUControlD = 3'b110;
                        FN_AND:  ALUControlD = 3'b000;
                        FN_OR:   ALUControlD = 3'b001;
                        FN_SLT:  ALUControlD = 3'b111;
                        default: ALUControlD = 3'b000;
                    endcase
                end
            end
            OP_LW: begin
                RegWriteD   = 1'b1;
                ALUSrcD     = 1'b1;
                MemtoRegD   = 1'b1;
                ALUControlD = 3'b010;
            end
            OP_SW: begin
                MemWriteD   = 1'b1;
                ALUSrcD     = 1'b1;
                ALUControlD = 3'b010;
            end
            OP_BEQ: begin
                BranchD     = 1'b1;
                ALUControlD = 3'b110;
            end
            OP_ADDI: begin
                RegWriteD   = 1'b1;
                ALUSrcD     = 1'b1;
                ALUControlD = 3'b010;
            end
            OP_J: begin
                JumpD = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cmp_a     = ForwardAD ? ALUOutM : RD1D;
    assign cmp_b     = ForwardBD ? ALUOutM : RD2D;
    assign PCSrcD    = BranchD & (cmp_a == cmp_b);
    assign PCBranchD = PCPlus4D + {SignImmD[DATA_W-3:0], 2'b00};
    assign PCJumpD   = {PCPlus4D[DATA_W-1:DATA_W-4], InstrD[25:0], 2'b00};

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: register file, bypass, decode,
// branch/jump targets and asynchronous reset.
module tb_decode_stage;

    logic        CLK;
    logic        RST;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        ForwardAD;
    logic        ForwardBD;
    logic [31:0] ALUOutM;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  RdD;
    logic [31:0] SignImmD;
    logic        RegWriteD;
    logic        MemtoRegD;
    logic        MemWriteD;
    logic        ALUSrcD;
    logic        RegDstD;
    logic        BranchD;
    logic        JumpD;
    logic [2:0]  ALUControlD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic [31:0] PCJumpD;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .CLK(CLK), .RST(RST), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM),
        .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .SignImmD(SignImmD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
        .BranchD(BranchD), .JumpD(JumpD), .ALUControlD(ALUControlD),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // {RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst, Branch, Jump, ALUControl}
    function automatic logic [31:0] ctrl_vec();
        return {22'd0, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
                BranchD, JumpD, ALUControlD};
    endfunction

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        RegWriteW = 1'b1;
        WriteRegW = addr;
        ResultW   = data;
        @(posedge CLK);
        #1;
        RegWriteW = 1'b0;
    endtask

    task automatic read_pair(input logic [4:0] rs, input logic [4:0] rt);
        InstrD = rtype(rs, rt, 5'd0, 6'h20);
        #1;
    endtask

    logic [31:0] dec_instr [12];
    logic [9:0]  dec_exp   [12];
    string       dec_name  [12];

    initial begin
        RST = 1'b1; InstrD = '0; PCPlus4D = 32'hA5555554;
        RegWriteW = 1'b0; WriteRegW = '0; ResultW = '0;
        ForwardAD = 1'b0; ForwardBD = 1'b0; ALUOutM = '0;

        // Idle outputs while held in reset with a bubble instruction.
        #3;
        check("rst_ctrl", ctrl_vec(), 32'd0);
        check("rst_pcsrc", {31'd0, PCSrcD}, 32'd0);
        check("rst_pcjump", PCJumpD, 32'hA0000000);
        check("rst_rd1", RD1D, 32'd0);

        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;

        for (int i = 0; i < 32; i++) begin
            read_pair(5'(i), 5'(i));
            check($sformatf("reset_rd1_r%0d", i), RD1D, 32'd0);
            check($sformatf("reset_rd2_r%0d", i), RD2D, 32'd0);
        end

        write_reg(5'd5, 32'hDEADBEEF);
        read_pair(5'd5, 5'd0);
        check("wr5_rd1", RD1D, 32'hDEADBEEF);
        check("wr5_rd2_zero", RD2D, 32'd0);

        // Write-through: value visible before the edge commits it.
        RegWriteW = 1'b1; WriteRegW = 5'd7; ResultW = 32'h1234;
        InstrD = rtype(5'd5, 5'd7, 5'd0, 6'h20);
        #1;
        check("bypass_rd2", RD2D, 32'h1234);
        check("bypass_rd1_other", RD1D, 32'hDEADBEEF);
        @(posedge CLK); #1;
        RegWriteW = 1'b0;
        #1;
        check("array_rd2", RD2D, 32'h1234);

        // Bypass gated by enable: stale array value returned when RegWriteW=0.
        WriteRegW = 5'd7; ResultW = 32'h5555;
        #1;
        check("no_bypass_en0", RD2D, 32'h1234);

        // $0 write with coincident read.
        RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'hFFFF;
        InstrD = rtype(5'd0, 5'd0, 5'd0, 6'h20);
        #1;
        check("zero_bypass", RD1D, 32'd0);
        @(posedge CLK); #1;
        RegWriteW = 1'b0;
        #1;
        check("zero_after", RD2D, 32'd0);

        // Decode sweep.
        dec_instr[0]  = rtype(5'd1, 5'd2, 5'd3, 6'h20); dec_exp[0]  = 10'b1000100_010; dec_name[0]  = "add";
        dec_instr[1]  = rtype(5'd1, 5'd2, 5'd3, 6'h22); dec_exp[1]  = 10'b1000100_110; dec_name[1]  = "sub";
        dec_instr[2]  = rtype(5'd1, 5'd2, 5'd3, 6'h24); dec_exp[2]  = 10'b1000100_000; dec_name[2]  = "and";
        dec_instr[3]  = rtype(5'd1, 5'd2, 5'd3, 6'h25); dec_exp[3]  = 10'b1000100_001; dec_name[3]  = "or";
        dec_instr[4]  = rtype(5'd1, 5'd2, 5'd3, 6'h2A); dec_exp[4]  = 10'b1000100_111; dec_name[4]  = "slt";
        dec_instr[5]  = itype(6'h23, 5'd1, 5'd2, 16'h0004); dec_exp[5] = 10'b1101000_010; dec_name[5] = "lw";
        dec_instr[6]  = itype(6'h2B, 5'd1, 5'd2, 16'h0004); dec_exp[6] = 10'b0011000_010; dec_name[6] = "sw";
        dec_instr[7]  = itype(6'h08, 5'd1, 5'd2, 16'h0004); dec_exp[7] = 10'b1001000_010; dec_name[7] = "addi";
        dec_instr[8]  = itype(6'h04, 5'd1, 5'd2, 16'h0004); dec_exp[8] = 10'b0000010_110; dec_name[8] = "beq";
        dec_instr[9]  = 32'h08000010;                       dec_exp[9] = 10'b0000001_000; dec_name[9] = "j";
        dec_instr[10] = 32'hFFFFFFFF;                       dec_exp[10] = 10'd0;          dec_name[10] = "op3f";
        dec_instr[11] = 32'h00000000;                       dec_exp[11] = 10'd0;          dec_name[11] = "bubble";
        for (int i = 0; i < 12; i++) begin
            InstrD = dec_instr[i];
            #1;
            check({"dec_", dec_name[i]}, ctrl_vec(), {22'd0, dec_exp[i]});
        end
        InstrD = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        #1;
        check("dec_bad_funct", ctrl_vec(), 32'd0);

        // Field extraction and sign extension.
        InstrD = itype(6'h23, 5'd17, 5'd9, 16'h8A0C);
        #1;
        check("fields", {17'd0, RsD, RtD, RdD}, {17'd0, 5'd17, 5'd9, 5'd17});
        check("signimm_neg", SignImmD, 32'hFFFF8A0C);
        InstrD = itype(6'h08, 5'd0, 5'd0, 16'h7FFF);
        #1;
        check("signimm_pos", SignImmD, 32'h00007FFF);

        // Branch resolution.
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd5);
        InstrD = itype(6'h04, 5'd1, 5'd2, 16'hFFFE);
        PCPlus4D = 32'h00000100;
        #1;
        check("beq_taken", {31'd0, PCSrcD}, 32'd1);
        check("beq_target", PCBranchD, 32'h000000F8);
        write_reg(5'd2, 32'd6);
        #1;
        check("beq_not_taken", {31'd0, PCSrcD}, 32'd0);
        ForwardBD = 1'b1; ALUOutM = 32'd5;
        #1;
        check("beq_fwd_b", {31'd0, PCSrcD}, 32'd1);
        ForwardBD = 1'b0; ForwardAD = 1'b1; ALUOutM = 32'd6;
        #1;
        check("beq_fwd_a", {31'd0, PCSrcD}, 32'd1);
        ForwardAD = 1'b0;
        InstrD = itype(6'h04, 5'd3, 5'd3, 16'h0002);
        PCPlus4D = 32'hFFFFFFFC;
        #1;
        check("beq_wrap_target", PCBranchD, 32'h00000004);
        check("beq_zero_regs", {31'd0, PCSrcD}, 32'd1);
        InstrD = rtype(5'd1, 5'd1, 5'd3, 6'h22);
        #1;
        check("sub_equal_no_pcsrc", {31'd0, PCSrcD}, 32'd0);

        // Jump target.
        PCPlus4D = 32'hA0000004;
        InstrD = 32'h08000010;
        #1;
        check("j_jumpd", {31'd0, JumpD}, 32'd1);
        check("j_target", PCJumpD, 32'hA0000040);
        InstrD = 32'h0BFFFFFF;
        PCPlus4D = 32'h5000_0000;
        #1;
        check("j_target_max", PCJumpD, 32'h5FFFFFFC);

        // Asynchronous reset mid-cycle clears without a clock edge.
        write_reg(5'd3, 32'h33333333);
        write_reg(5'd4, 32'h44444444);
        write_reg(5'd31, 32'hF0F0F0F0);
        read_pair(5'd3, 5'd4);
        check("pre_rst_r3", RD1D, 32'h33333333);
        check("pre_rst_r4", RD2D, 32'h44444444);
        RST = 1'b1;
        #1;
        check("async_rst_r3", RD1D, 32'd0);
        check("async_rst_r4", RD2D, 32'd0);
        read_pair(5'd31, 5'd5);
        check("async_rst_r31", RD1D, 32'd0);
        check("async_rst_r5", RD2D, 32'd0);

        // Write attempted across an edge while reset is held: reset wins.
        RegWriteW = 1'b1; WriteRegW = 5'd9; ResultW = 32'h99999999;
        @(posedge CLK); #1;
        RegWriteW = 1'b0;
        read_pair(5'd9, 5'd0);
        check("rst_wins_r9", RD1D, 32'd0);
        #2 RST = 1'b0;
        #1;
        check("post_rst_r9", RD1D, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the 5-stage MiniMIPS pipeline. It consumes `InstrD`/`PCPlus4D` from the fetch-to-decode pipeline register and holds the 32×32 register file, which is written by the writeback stage. It produces control signals, operands and immediates for the decode-to-execute register. It also resolves branches and jumps early, and its `PCSrcD` flushes the fetch-to-decode register.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; fixed at 32 for this ISA.
- `REG_N`, 32, number of architectural registers; fixed at 32.

Ports:
- `CLK`  in  1  single clock; register file writes on rising edge.
- `RST`  in  1  asynchronous, active-high reset; clears all registers.
- `InstrD`  in  32  instruction from the fetch-to-decode register.
- `PCPlus4D`  in  32  PC+4 of `InstrD`.
- `RegWriteW`  in  1  writeback write enable.
- `WriteRegW`  in  5  writeback destination register.
- `ResultW`  in  32  writeback data.
- `ForwardAD`, `ForwardBD`  in  1 each  from the hazard unit; select `ALUOutM` as the branch-compare operand A/B.
- `ALUOutM`  in  32  memory-stage ALU result, used for branch forwarding.
- `RD1D`, `RD2D`  out  32  register read data for rs/rt.
- `RsD`, `RtD`, `RdD`  out  5  `InstrD[25:21]`, `[20:16]`, `[15:11]`.
- `SignImmD`  out  32  sign-extended `InstrD[15:0]`.
- `RegWriteD`, `MemtoRegD`, `MemWriteD`, `ALUSrcD`, `RegDstD`, `BranchD`, `JumpD`  out  1 each  control signals.
- `ALUControlD`  out  3  ALU operation.
- `PCSrcD`  out  1  branch taken.
- `PCBranchD`  out  32  branch target.
- `PCJumpD`  out  32  jump target.

## Operation
**Register file**
- 32 entries of 32 bits.
- Write occurs on rising `CLK` when `RegWriteW` is 1 and `WriteRegW` ≠ 0.
- `$0` always reads 0; writes to `$0` are ignored.
- Write-through bypass: if `RegWriteW` is 1, `WriteRegW` ≠ 0 and `WriteRegW` equals the read address, the read port returns `ResultW` in the same cycle. This resolves the WB→ID hazard without a negedge write.
- Asynchronous `RST` clears all 32 entries to 0.

**Control decode** (combinational from `InstrD[31:26]` and `[5:0]`):
- R-type (op 0x00): RegWrite=1, RegDst=1, all other control flags 0. Funct decodes to ALUControl as follows:
  - add 0x20 → 010
  - sub 0x22 → 110
  - and 0x24 → 000
  - or 0x25 → 001
  - slt 0x2A → 111
- lw (0x23): RegWrite=1, ALUSrc=1, MemtoReg=1, ALUControl=010.
- sw (0x2B): MemWrite=1, ALUSrc=1, ALUControl=010.
- beq (0x04): Branch=1, ALUControl=110.
- addi (0x08): RegWrite=1, ALUSrc=1, ALUControl=010.
- j (0x02): Jump=1.
- Any other opcode, or R-type with an unsupported funct (including the all-zero bubble `InstrD`=0): every control output is 0 and ALUControl=000. This makes the instruction a true NOP.

**Branch and jump**
- Compare operand A = `ForwardAD` ? `ALUOutM` : `RD1D`. Operand B is selected the same way from `ForwardBD` and `RD2D`.
- `PCSrcD` = `BranchD` & (A == B).
- `PCBranchD` = `PCPlus4D` + (`SignImmD` << 2), computed mod 2^32 with wrap-around permitted.
- `PCJumpD` = {`PCPlus4D[31:28]`, `InstrD[25:0]`, 2'b00}.

## Timing
- All outputs are combinational from `InstrD`, `PCPlus4D`, the register state and the WB/forward inputs. Decode latency is 0 cycles, and the outputs are registered downstream.
- Register write latency: a value written at edge N is visible from the array after N. It is visible before N through the bypass.
- During and immediately after `RST`, all registers read 0. With `InstrD`=0, every control output is 0, `PCSrcD`=0, and `PCJumpD` = {`PCPlus4D[31:28]`, 28'b0}.
- `RST` asserted mid-write: the reset wins and the entry reads 0.
- Simultaneous write and read of the same register: the read returns `ResultW`.
- A write to `$0` that coincides with a read of `$0`: the read returns 0.

## Test plan
- Reset, then read every register → all 0. Then write `$5`=0xDEADBEEF with `RegWriteW`=1 at edge; read rs=5 next cycle → `RD1D`=0xDEADBEEF.
- Write-through: `RegWriteW`=1, `WriteRegW`=7, `ResultW`=0x1234, and `InstrD` reads rt=7 in the same cycle → `RD2D`=0x1234 before the edge. Then write `$0`=0xFFFF → `$0` reads 0.
- Decode sweep: add/sub/and/or/slt/lw/sw/addi/beq/j plus opcode 0x3F and `InstrD`=0 → control vectors exactly as in Operation; the last two are all-zero.
- Branch: beq $1,$2 with `$1`=`$2`=5, `PCPlus4D`=0x100, imm=0xFFFE → `PCSrcD`=1, `PCBranchD`=0xF8. With `$2`=6 → `PCSrcD`=0. With `ForwardBD`=1 and `ALUOutM`=5 → `PCSrcD`=1.
- Jump: `PCPlus4D`=0xA0000004, `InstrD`=0x08000010 → `JumpD`=1, `PCJumpD`=0xA0000040.
- Reset asserted asynchronously mid-cycle after several writes → all registers read 0 immediately, without waiting for a clock edge.
